alarm_unit: RTL
===============

Name: alarm_unit

Overview:
- Downstream consumer of the regular_clock time outputs (hour, min, sec).
- Holds a programmable alarm time and raises a ringing output when the running clock reaches it.
- Supports snooze (re-arm N minutes later), stop, auto-timeout and disarm.
- Sits between the clock core and the user-facing buzzer/LED logic.

Parameters:
- RING_SECS, 60, number of seconds ringing stays asserted before auto-stop.
- SNOOZE_MIN, 5, minutes added to the current trigger time on each snooze.
- MAX_SNOOZE, 3, maximum consecutive snoozes; further snooze presses are ignored.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- hour  in  6  current hour from regular_clock, 0..23.
- min  in  6  current minute, 0..59.
- sec  in  6  current second, 0..59.
- arm  in  1  level; 1 = alarm enabled.
- set_en  in  1  one-cycle pulse; load set_hour/set_min as the alarm time.
- set_hour  in  6  alarm hour to load.
- set_min  in  6  alarm minute to load.
- snooze  in  1  one-cycle pulse.
- stop  in  1  one-cycle pulse.
- ringing  out  1  registered; alarm active.
- armed  out  1  registered; 1 in ARMED, RINGING or SNOOZE.
- set_err  out  1  one-cycle pulse; rejected set request.
- alarm_hour  out  6  programmed alarm hour.
- alarm_min  out  6  programmed alarm minute.
- snooze_cnt  out  2  snoozes used since last ring start.

Behaviour:
- Reset (reset == 0 at a clk edge):
  - State IDLE.
  - ringing, armed, set_err, snooze_cnt = 0.
  - alarm_hour = alarm_min = 0.
  - Trigger time = 00:00.
  - Ring counter = 0.
  - Previous-match flag and sec_prev cleared.
  - Applies mid-ring: ringing is 0 in the cycle after reset is sampled.
- Set request (set_en = 1):
  - Accepted only in IDLE or ARMED.
  - Valid values (set_hour <= 23, set_min <= 59) load both alarm_hour/alarm_min and the trigger time next cycle.
  - Out-of-range values leave all registers unchanged and pulse set_err for one cycle.
  - In RINGING or SNOOZE, set_en is ignored with no set_err.
- match = (hour == trig_h) && (min == trig_m) && (sec == 0).
  - The block acts only on the rising edge of match (match & ~match_prev).
  - A clock held by its enable at the trigger time therefore fires once.
- Second tick = (sec != sec_prev). Only second ticks advance the ring counter.
- FSM:
  - IDLE: arm = 1 -> ARMED.
  - ARMED:
    - Match edge -> RINGING; ringing = 1 on the next clk edge (1-cycle latency); ring counter cleared.
    - arm = 0 -> IDLE.
  - RINGING, evaluated in priority order:
    1. arm = 0 -> IDLE.
    2. stop -> ARMED; trigger time restored to alarm time; snooze_cnt = 0.
    3. snooze with snooze_cnt < MAX_SNOOZE -> SNOOZE; trigger = current trigger + SNOOZE_MIN; snooze_cnt + 1.
    4. snooze with snooze_cnt == MAX_SNOOZE -> ignored, stays RINGING.
    5. Ring counter reaches RING_SECS second ticks -> ARMED; trigger restored; snooze_cnt = 0.
  - SNOOZE:
    - ringing = 0.
    - Match edge on the snoozed trigger -> RINGING (snooze_cnt kept).
    - arm = 0 -> IDLE; trigger restored; snooze_cnt = 0.
- Simultaneous stop and snooze: stop wins. Any event with arm = 0: disarm wins.
- Trigger arithmetic:
  - Minute sum wraps mod 60 and carries into the hour.
  - Hour wraps mod 24, so 23:58 + 5 = 00:03.
  - Adder inputs are 6-bit; intermediate sums use 7 bits.
- ringing and armed are registered and never glitch.

Decomposition:
- Package alarm_pkg:
  - State enum {IDLE, ARMED, RINGING, SNOOZE}.
  - Constants MIN_PER_HOUR = 60, HOURS_PER_DAY = 24.
- Sub-module time_add_min: combinational hour/min + minutes adder with wrap, used for the snooze trigger.

Test Plan:
- Reset with hour/min/sec = 07:30:00, arm = 1 -> ringing = 0, armed = 0 (IDLE), alarm = 00:00 until reset released.
- set_en with 07:30, arm = 1, clock counts 07:29:59 -> 07:30:00 -> ringing = 1 exactly one clk after sec = 0; deasserts after 60 second ticks; state ARMED.
- set_en with 24:10 -> set_err pulses one cycle; alarm_hour/alarm_min stay 07:30. set_en with 12:60 -> same result.
- Ring at 23:58, snooze -> ringing = 0, snooze_cnt = 1; ringing reasserts at 00:03:00. Snooze three times -> the fourth snooze is ignored and ringing stays 1.
- stop and snooze pulsed in the same cycle while ringing -> ARMED, snooze_cnt = 0, trigger back to alarm time.
- Clock enable held low at 07:30:00 for 20 cycles -> single ring entry, no retrigger. Drop arm mid-ring -> ringing = 0 next cycle, state IDLE.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm unit: FSM state encoding and
// time-of-day limits used by the trigger arithmetic and set validation.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } alarm_state_e;

    localparam int MIN_PER_HOUR  = 60;
    localparam int HOURS_PER_DAY = 24;

    function automatic logic time_valid(input logic [5:0] h, input logic [5:0] m);
        return (h < 6'(HOURS_PER_DAY)) && (m < 6'(MIN_PER_HOUR));
    endfunction

endpackage

// File: rtl/time_add_min.sv
// Combinational hh:mm + minutes adder; minutes wrap into the hour and the
// hour wraps at midnight. add_min is expected to be below one hour.
module time_add_min
    import alarm_pkg::*;
(
    input  logic [5:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] add_min,
    output logic [5:0] sum_hour,
    output logic [5:0] sum_min
);

    logic [6:0] min_sum;
    logic [6:0] min_wrap;
    logic [6:0] hour_sum;
    logic [6:0] hour_wrap;
    logic       carry;

    always_comb begin
        min_sum  = {1'b0, min} + {1'b0, add_min};
        min_wrap = min_sum;
        carry    = 1'b0;
        if (min_sum >= 7'(MIN_PER_HOUR)) begin
            min_wrap = min_sum - 7'(MIN_PER_HOUR);
            carry    = 1'b1;
        end

        hour_sum  = {1'b0, hour} + 7'(carry);
        hour_wrap = hour_sum;
        if (hour_sum >= 7'(HOURS_PER_DAY)) begin
            hour_wrap = hour_sum - 7'(HOURS_PER_DAY);
        end

        sum_min  = min_wrap[5:0];
        sum_hour = hour_wrap[5:0];
    end

endmodule

// File: rtl/alarm_unit.sv
// Alarm controller: compares the running time against a trigger time and
// drives a registered ringing output with snooze, stop, timeout and disarm.
module alarm_unit
    import alarm_pkg::*;
#(
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic       arm,
    input  logic       set_en,
    input  logic [5:0] set_hour,
    input  logic [5:0] set_min,
    input  logic       snooze,
    input  logic       stop,
    output logic       ringing,
    output logic       armed,
    output logic       set_err,
    output logic [5:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic [1:0] snooze_cnt
);

    localparam int RW = $clog2(RING_SECS + 1);

    alarm_state_e state, next_state;
    logic [5:0]    trig_h, trig_m;
    logic [5:0]    snz_h, snz_m;
    logic [RW-1:0] ring_cnt;
    logic [5:0]    sec_prev;
    logic          match_prev;
    logic          match, match_edge, sec_tick;
    logic          can_snooze, ring_done, set_accept, set_ok;

    time_add_min u_snooze_add (
        .hour    (trig_h),
        .min     (trig_m),
        .add_min (6'(SNOOZE_MIN)),
        .sum_hour(snz_h),
        .sum_min (snz_m)
    );

    assign match      = (hour == trig_h) && (min == trig_m) && (sec == 6'd0);
    assign match_edge = match && !match_prev;
    assign sec_tick   = (sec != sec_prev);
    assign can_snooze = (snooze_cnt < 2'(MAX_SNOOZE));
    assign ring_done  = sec_tick && (ring_cnt == RW'(RING_SECS - 1));
    assign set_accept = set_en && ((state == IDLE) || (state == ARMED));
    assign set_ok     = time_valid(set_hour, set_min);

    // Disarm always takes precedence, then stop over snooze, then timeout.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (arm) next_state = ARMED;
            ARMED:   if (!arm) next_state = IDLE;
                     else if (match_edge) next_state = RINGING;
            RINGING: if (!arm) next_state = IDLE;
                     else if (stop) next_state = ARMED;
                     else if (snooze && can_snooze) next_state = SNOOZE;
                     else if (ring_done) next_state = ARMED;
            SNOOZE:  if (!arm) next_state = IDLE;
                     else if (match_edge) next_state = RINGING;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            ringing    <= 1'b0;
            armed      <= 1'b0;
            set_err    <= 1'b0;
            snooze_cnt <= 2'd0;
            alarm_hour <= 6'd0;
            alarm_min  <= 6'd0;
            trig_h     <= 6'd0;
            trig_m     <= 6'd0;
            ring_cnt   <= '0;
            match_prev <= 1'b0;
            sec_prev   <= 6'd0;
        end else begin
            state      <= next_state;
            ringing    <= (next_state == RINGING);
            armed      <= (next_state != IDLE);
            set_err    <= set_accept && !set_ok;
            match_prev <= match;
            sec_prev   <= sec;

            if (next_state == RINGING && state != RINGING) begin
                ring_cnt <= '0;
            end else if (state == RINGING && sec_tick) begin
                ring_cnt <= ring_cnt + RW'(1);
            end

            // Leaving a ring (or disarming) puts the trigger back on the programmed time.
            if (state == RINGING && next_state == SNOOZE) begin
                trig_h     <= snz_h;
                trig_m     <= snz_m;
                snooze_cnt <= snooze_cnt + 2'd1;
            end else if (next_state == IDLE || (state == RINGING && next_state == ARMED)) begin
                trig_h     <= alarm_hour;
                trig_m     <= alarm_min;
                snooze_cnt <= 2'd0;
            end else if (state == ARMED && next_state == RINGING) begin
                snooze_cnt <= 2'd0;
            end

            if (set_accept && set_ok) begin
                alarm_hour <= set_hour;
                alarm_min  <= set_min;
                trig_h     <= set_hour;
                trig_m     <= set_min;
            end
        end
    end

endmodule
